// File: rtl/wb_timer.sv
// wb_timer: bus-mapped 32-bit down-counter with prescaler, auto-reload and a
// level interrupt. Registers are selected by io_bus_addr[3:2].
module wb_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] io_bus_addr,
    input  logic [31:0] io_bus_dat2,
    output logic [31:0] io_bus_dat4,
    input  logic        io_bus_sel,
    input  logic        io_bus_we,
    output logic        io_bus_ack,
    output logic        io_irq
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_addr_e;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic        ack_q;
    logic [31:0] rdata_q;
    logic        ctrl_enable;
    logic        ctrl_auto_reload;
    logic        ctrl_irq_en;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        status_expired;
    logic [15:0] presc_cnt;

    reg_addr_e   reg_sel;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        count_tick;
    logic        expire;
    logic [31:0] read_mux;
    logic        unused_addr_bits;

    // Only bits [3:2] select a register; the rest of the address is ignored.
    assign unused_addr_bits = ^{io_bus_addr[31:4], io_bus_addr[1:0]};
    assign reg_sel          = reg_addr_e'(io_bus_addr[3:2]);

    // Bus decode plus tick/expiry qualification; a COUNT write masks the tick.
    always_comb begin
        accept     = io_bus_sel & ~ack_q;
        wr_en      = accept & io_bus_we;
        rd_en      = accept & ~io_bus_we;
        wr_ctrl    = wr_en && (reg_sel == REG_CTRL);
        wr_load    = wr_en && (reg_sel == REG_LOAD);
        wr_count   = wr_en && (reg_sel == REG_COUNT);
        wr_status  = wr_en && (reg_sel == REG_STATUS);
        tick       = ctrl_enable && (presc_cnt == PRESCALE_LAST);
        count_tick = tick && !wr_count;
        expire     = count_tick && (count_q == 32'd0);
    end

    // Read multiplexer over the pre-edge register values.
    always_comb begin
        read_mux = 32'd0;
        case (reg_sel)
            REG_CTRL:   read_mux = {29'd0, ctrl_irq_en, ctrl_auto_reload, ctrl_enable};
            REG_LOAD:   read_mux = load_q;
            REG_COUNT:  read_mux = count_q;
            REG_STATUS: read_mux = {31'd0, status_expired};
            default:    read_mux = 32'd0;
        endcase
    end

    // One-cycle ack after each accepted request; read data is held only for reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q   <= accept;
            rdata_q <= rd_en ? read_mux : 32'd0;
        end
    end

    // Prescaler runs only while enabled and restarts on every COUNT write.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt <= 16'd0;
        end else if (!ctrl_enable || wr_count) begin
            presc_cnt <= 16'd0;
        end else if (presc_cnt == PRESCALE_LAST) begin
            presc_cnt <= 16'd0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // CTRL: bus write beats the one-shot expiry clearing enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_enable      <= io_bus_dat2[0];
            ctrl_auto_reload <= io_bus_dat2[1];
            ctrl_irq_en      <= io_bus_dat2[2];
        end else if (expire && !ctrl_auto_reload) begin
            ctrl_enable <= 1'b0;
        end
    end

    // LOAD only feeds COUNT at the next reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q <= 32'd0;
        end else if (wr_load) begin
            load_q <= io_bus_dat2;
        end
    end

    // COUNT: bus write wins; otherwise decrement, reload at zero, or hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (wr_count) begin
            count_q <= io_bus_dat2;
        end else if (count_tick) begin
            if (count_q != 32'd0) begin
                count_q <= count_q - 32'd1;
            end else if (ctrl_auto_reload) begin
                count_q <= load_q;
            end
        end
    end

    // STATUS.expired: expiry set wins over a same-edge write-one-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_expired <= 1'b0;
        end else if (expire) begin
            status_expired <= 1'b1;
        end else if (wr_status && io_bus_dat2[0]) begin
            status_expired <= 1'b0;
        end
    end

    assign io_bus_ack  = ack_q;
    assign io_bus_dat4 = rdata_q;
    assign io_irq      = status_expired & ctrl_irq_en;

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter PRESCALE, default 1, counter ticks once every PRESCALE clk cycles (legal range 1..65535).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 io_bus_addr  input  32  byte address from bus; only bits [3:2] decoded, all others ignored.
REQ-005 io_bus_dat2  input  32  write data from bus master.
REQ-006 io_bus_dat4  output  32  read data to bus master.
REQ-007 io_bus_sel  input  1  request strobe from bus.
REQ-008 io_bus_we  input  1  1 = write, 0 = read; sampled only with io_bus_sel.
REQ-009 io_bus_ack  output  1  transaction complete, one-cycle pulse.
REQ-010 io_irq  output  1  level interrupt = STATUS.expired & CTRL.irq_en.

Function
REQ-011 Register map by addr[3:2]: 0 CTRL (bit0 enable, bit1 auto_reload, bit2 irq_en, bits[31:3] read 0); 1 LOAD (32 bit); 2 COUNT (32 bit); 3 STATUS (bit0 expired, bits[31:1] read 0).
REQ-012 Request accepted in a cycle where io_bus_sel=1 and io_bus_ack=0; io_bus_ack SHALL be 1 in the next cycle only.
REQ-013 io_bus_sel=1 while io_bus_ack=1 SHALL be ignored; a continuously held sel yields one accepted transaction every 2 cycles.
REQ-014 Write commits at the clock edge that raises io_bus_ack; writes to read-only bits are discarded.
REQ-015 Read data SHALL be captured at the accepting edge from pre-edge register values and held on io_bus_dat4 while io_bus_ack=1; io_bus_dat4 = 0 otherwise.
REQ-016 Write accept cycles SHALL drive io_bus_dat4 = 0 during the ack cycle.
REQ-017 Prescaler counter counts 0..PRESCALE-1 while CTRL.enable=1, wraps to 0, and issues a tick on the cycle it equals PRESCALE-1; PRESCALE=1 ticks every enabled cycle.
REQ-018 Prescaler SHALL clear to 0 whenever CTRL.enable=0 or on any COUNT write.
REQ-019 On tick with COUNT>0: COUNT decrements by 1.
REQ-020 On tick with COUNT=0: STATUS.expired set to 1; if auto_reload=1, COUNT <= LOAD and enable stays 1; else COUNT stays 0 and CTRL.enable cleared to 0.
REQ-021 Bus write to COUNT in the same edge as a tick SHALL win; no decrement, reload or expiry that edge.
REQ-022 Bus write to CTRL in the same edge as an expiry-clear of enable SHALL win.
REQ-023 STATUS write with dat2[0]=1 clears expired; dat2[0]=0 has no effect; same-edge set by expiry SHALL win over clear.
REQ-024 LOAD write has no effect on COUNT until next reload.
REQ-025 COUNT arithmetic is unsigned 32-bit; no wrap below 0 (REQ-020 applies instead).
REQ-026 io_irq SHALL be combinational from registered bits, no added latency.

Reset
REQ-027 While reset=1 at an edge: CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0, io_bus_ack=0, read-data register=0.
REQ-028 Outputs after reset: io_bus_ack=0, io_bus_dat4=0, io_irq=0.
REQ-029 Reset asserted mid-transaction (ack pending or high) SHALL drop ack next cycle; the in-flight write SHALL NOT commit if reset coincides with its accepting edge.

Verification
REQ-030 Write LOAD=5, COUNT=3, CTRL=0x7 (PRESCALE=1) -> COUNT reads 2,1,0 on successive ticks, expired=1 on 4th tick, COUNT=5 after, io_irq=1.
REQ-031 CTRL=0x1 (one-shot), COUNT=2 -> after 3 ticks expired=1, CTRL reads 0x0, COUNT holds 0, io_irq=0 (irq_en=0).
REQ-032 sel held high 6 cycles, read addr 0x4 with LOAD=0xDEADBEEF -> ack high in cycles 2,4,6 only, dat4=0xDEADBEEF each ack, 0 elsewhere.
REQ-033 Write COUNT=0x10 on the same edge COUNT reaches 0 with auto_reload -> COUNT=0x10, expired stays 0.
REQ-034 Write STATUS=1 on the same edge as expiry -> expired reads 1; next STATUS=1 write -> expired 0, io_irq 0.
REQ-035 PRESCALE=4, COUNT=2, enable -> COUNT decrements every 4th cycle; reset mid-count -> all registers 0, ack 0 next cycle.
